// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the signals between the microcode sequencer and the rest of the 8-bit CPU.
//   Signals:
//     IR_OP  [3:0]  opcode nibble from the instruction register (upper 4 bits of IR)
//     CF            carry flag from the ALU flag register
//     ZF            zero flag from the ALU flag register
//     CTRL   [15:0] control word {HLT,MI,RI,RO,IO,II,AI,AO,EO_n,SU,BI,OI,CE,CO,J,FI_n}
//     STEP   [2:0]  current microstep, for visibility
//     HALTED        set once HLT has executed, cleared only by reset
//   Handshake: there is no valid/ready pair on this bus. Every signal is level-sensitive
//   and meaningful on every cycle: the datapath acts on CTRL at each rising edge, and
//   IR_OP/CF/ZF are taken as whatever value they hold in the current cycle.
//   Modports: master = sequencer side (drives CTRL/STEP/HALTED),
//             slave  = datapath side (drives IR_OP/CF/ZF).
interface control_sequencer_if;
  logic [3:0]  IR_OP;
  logic        CF;
  logic        ZF;
  logic [15:0] CTRL;
  logic [2:0]  STEP;
  logic        HALTED;

  modport master (
    input  IR_OP,
    input  CF,
    input  ZF,
    output CTRL,
    output STEP,
    output HALTED
  );

  modport slave (
    output IR_OP,
    output CF,
    output ZF,
    input  CTRL,
    input  STEP,
    input  HALTED
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcode control sequencer for the 8-bit CPU. Steps each instruction through
//   fetch (T0, T1) and execute (T2..T4) microsteps and decodes the opcode into a
//   16-bit control word. JC/JZ consult CF/ZF at T2. HLT freezes the sequencer.
//   Parameters:
//     MAX_STEP   last legal microstep index (4..7, 3-bit step counter)
//     EARLY_END  1: wrap to T0 after an opcode's last used step; 0: always run to MAX_STEP
//   Ports:
//     CLK   system clock, rising edge
//     CLR   asynchronous active-high reset
//     bus   control_sequencer_if.master: IR_OP/CF/ZF in, CTRL/STEP/HALTED out
module control_sequencer #(
  parameter int MAX_STEP  = 4,
  parameter bit EARLY_END = 1'b1
) (
  input  logic                       CLK,
  input  logic                       CLR,
  control_sequencer_if.master        bus
);

  // Control word bit positions, bit15..bit0.
  localparam logic [15:0] C_HLT  = 16'h8000;
  localparam logic [15:0] C_MI   = 16'h4000;
  localparam logic [15:0] C_RI   = 16'h2000;
  localparam logic [15:0] C_RO   = 16'h1000;
  localparam logic [15:0] C_IO   = 16'h0800;
  localparam logic [15:0] C_II   = 16'h0400;
  localparam logic [15:0] C_AI   = 16'h0200;
  localparam logic [15:0] C_AO   = 16'h0100;
  localparam logic [15:0] C_SU   = 16'h0040;
  localparam logic [15:0] C_BI   = 16'h0020;
  localparam logic [15:0] C_OI   = 16'h0010;
  localparam logic [15:0] C_CE   = 16'h0008;
  localparam logic [15:0] C_CO   = 16'h0004;
  localparam logic [15:0] C_J    = 16'h0002;
  // EO_n and FI_n high: ALU off the bus, flags held.
  localparam logic [15:0] IDLE   = 16'h0081;

  localparam logic [2:0]  LAST_LEGAL = 3'(MAX_STEP);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_q;
  logic [2:0]  step_q;
  logic [2:0]  step_d;
  logic [2:0]  last_step;
  logic [15:0] ctrl_run;
  logic        halt_now;
  logic        at_end;

  // Last used microstep of the current opcode; only matters with EARLY_END=1.
  always_comb begin
    last_step = 3'd1;
    case (bus.IR_OP)
      4'h1, 4'h4:                             last_step = 3'd3;
      4'h2, 4'h3:                             last_step = 3'd4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF:     last_step = 3'd2;
      default:                                last_step = 3'd1;
    endcase
  end

  // Microcode decode of (STEP, IR_OP, CF, ZF).
  always_comb begin
    ctrl_run = IDLE;
    case (step_q)
      3'd0: ctrl_run = IDLE | C_CO | C_MI;
      3'd1: ctrl_run = IDLE | C_RO | C_II | C_CE;
      3'd2: begin
        case (bus.IR_OP)
          4'h1, 4'h2, 4'h3, 4'h4: ctrl_run = IDLE | C_IO | C_MI;
          4'h5:                   ctrl_run = IDLE | C_IO | C_AI;
          4'h6:                   ctrl_run = IDLE | C_IO | C_J;
          4'h7:                   ctrl_run = bus.CF ? (IDLE | C_IO | C_J) : IDLE;
          4'h8:                   ctrl_run = bus.ZF ? (IDLE | C_IO | C_J) : IDLE;
          4'hE:                   ctrl_run = IDLE | C_AO | C_OI;
          4'hF:                   ctrl_run = IDLE | C_HLT;
          default:                ctrl_run = IDLE;
        endcase
      end
      3'd3: begin
        case (bus.IR_OP)
          4'h1:       ctrl_run = IDLE | C_RO | C_AI;
          4'h2, 4'h3: ctrl_run = IDLE | C_RO | C_BI;
          4'h4:       ctrl_run = IDLE | C_AO | C_RI;
          default:    ctrl_run = IDLE;
        endcase
      end
      3'd4: begin
        // ALU result onto the bus (EO_n=0) and flags latched (FI_n=0).
        case (bus.IR_OP)
          4'h2:    ctrl_run = C_AI;
          4'h3:    ctrl_run = C_AI | C_SU;
          default: ctrl_run = IDLE;
        endcase
      end
      default: ctrl_run = IDLE;
    endcase
  end

  always_comb begin
    at_end   = (step_q == LAST_LEGAL) || (EARLY_END && (step_q == last_step));
    step_d   = at_end ? 3'd0 : step_q + 3'd1;
    halt_now = (bus.IR_OP == 4'hF) && (step_q == 3'd2);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_RUN;
      step_q  <= 3'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_now) begin
            state_q <= ST_HALT;
            step_q  <= 3'd0;
          end else begin
            step_q  <= step_d;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
          step_q  <= step_q;
        end
        default: begin
          state_q <= ST_RUN;
          step_q  <= 3'd0;
        end
      endcase
    end
  end

  // CLR gates the word directly so the datapath goes idle without waiting for a clock.
  assign bus.CTRL   = (CLR || (state_q == ST_HALT)) ? IDLE : ctrl_run;
  assign bus.STEP   = step_q;
  assign bus.HALTED = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int MAXS = 4;

  localparam logic [15:0] W_IDLE = 16'h0081;
  localparam logic [15:0] W_T0   = 16'h4085;
  localparam logic [15:0] W_T1   = 16'h1489;
  localparam logic [15:0] W_IOMI = 16'h4881;
  localparam logic [15:0] W_ROAI = 16'h1281;
  localparam logic [15:0] W_ROBI = 16'h10A1;
  localparam logic [15:0] W_ADD4 = 16'h0200;
  localparam logic [15:0] W_SUB4 = 16'h0240;
  localparam logic [15:0] W_AORI = 16'h2181;
  localparam logic [15:0] W_LDI  = 16'h0A81;
  localparam logic [15:0] W_JMP  = 16'h0883;
  localparam logic [15:0] W_OUT  = 16'h0191;
  localparam logic [15:0] W_HLT  = 16'h8081;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] op;
  logic       cf;
  logic       zf;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUTs: index 0 EARLY_END=1, index 1 EARLY_END=0 ----------------
  control_sequencer_if bus_a ();
  control_sequencer_if bus_b ();

  assign bus_a.IR_OP = op;
  assign bus_a.CF    = cf;
  assign bus_a.ZF    = zf;
  assign bus_b.IR_OP = op;
  assign bus_b.CF    = cf;
  assign bus_b.ZF    = zf;

  control_sequencer #(.MAX_STEP(MAXS), .EARLY_END(1'b1)) dut_a (
    .CLK (clk),
    .CLR (clr),
    .bus (bus_a)
  );

  control_sequencer #(.MAX_STEP(MAXS), .EARLY_END(1'b0)) dut_b (
    .CLK (clk),
    .CLR (clr),
    .bus (bus_b)
  );

  logic [15:0] ctrl_w [2];
  logic [2:0]  step_w [2];
  logic        halt_w [2];
  assign ctrl_w[0] = bus_a.CTRL;
  assign ctrl_w[1] = bus_b.CTRL;
  assign step_w[0] = bus_a.STEP;
  assign step_w[1] = bus_b.STEP;
  assign halt_w[0] = bus_a.HALTED;
  assign halt_w[1] = bus_b.HALTED;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An instruction is the list of control words it emits: two fetch words, then its
  // execute words. Its length decides where an early-ending instruction wraps.
  function automatic logic [15:0] model_word(input logic [3:0] o, input logic c, input logic z,
                                             input int s, output int len);
    logic [15:0] q[$];
    q.push_back(W_T0);
    q.push_back(W_T1);
    case (o)
      4'h1: begin q.push_back(W_IOMI); q.push_back(W_ROAI); end
      4'h2: begin q.push_back(W_IOMI); q.push_back(W_ROBI); q.push_back(W_ADD4); end
      4'h3: begin q.push_back(W_IOMI); q.push_back(W_ROBI); q.push_back(W_SUB4); end
      4'h4: begin q.push_back(W_IOMI); q.push_back(W_AORI); end
      4'h5: q.push_back(W_LDI);
      4'h6: q.push_back(W_JMP);
      4'h7: q.push_back(c ? W_JMP : W_IDLE);
      4'h8: q.push_back(z ? W_JMP : W_IDLE);
      4'hE: q.push_back(W_OUT);
      4'hF: q.push_back(W_HLT);
      default: ;
    endcase
    len = q.size();
    return (s < len) ? q[s] : W_IDLE;
  endfunction

  int m_step [2] = '{0, 0};
  bit m_halt [2] = '{0, 0};

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 2; i++) begin
        m_step[i] = 0;
        m_halt[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int len;
        int last;
        logic [15:0] w;
        if (!m_halt[i]) begin
          w    = model_word(op, cf, zf, m_step[i], len);
          last = (i == 0) ? len - 1 : MAXS;
          if (op == 4'hF && m_step[i] == 2) begin
            m_halt[i] = 1'b1;
            m_step[i] = 0;
          end else if (m_step[i] == last || m_step[i] == MAXS) begin
            m_step[i] = 0;
          end else begin
            m_step[i] = m_step[i] + 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare (negedge, away from the active edge) ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int len;
      logic [15:0] exp_ctrl;
      logic [15:0] c;
      int drivers;
      exp_ctrl = model_word(op, cf, zf, m_step[i], len);
      if (clr || m_halt[i]) exp_ctrl = W_IDLE;
      chk(i == 0 ? "ctrl_a" : "ctrl_b", {16'h0, ctrl_w[i]}, {16'h0, exp_ctrl});
      chk(i == 0 ? "step_a" : "step_b", {29'h0, step_w[i]}, 32'(m_step[i]));
      chk(i == 0 ? "halted_a" : "halted_b", {31'h0, halt_w[i]}, {31'h0, m_halt[i]});
      c = ctrl_w[i];
      drivers = int'(!c[7]) + int'(c[8]) + int'(c[12]) + int'(c[11]) + int'(c[2]);
      chk(i == 0 ? "bus_drv_a" : "bus_drv_b",
          {31'h0, (drivers <= 1) && (c[0] || !c[7])}, 32'h1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1;
    op  = 4'h0;
    cf  = 1'b0;
    zf  = 1'b0;

    // Reset held, then release into fetch.
    repeat (3) tick();
    chk("rst_ctrl", {16'h0, bus_a.CTRL}, {16'h0, W_IDLE});
    chk("rst_step", {29'h0, bus_a.STEP}, 32'h0);
    chk("rst_halted", {31'h0, bus_a.HALTED}, 32'h0);
    #1; clr = 1'b0; op = 4'h2;
    #1; chk("t0_fetch", {16'h0, bus_a.CTRL}, {16'h0, W_T0});

    // ADD: 0,1,2,3,4,0
    tick(); chk("add_t1", {16'h0, bus_a.CTRL}, {16'h0, W_T1});
    tick(); chk("add_t2", {16'h0, bus_a.CTRL}, {16'h0, W_IOMI});
    tick(); chk("add_t3", {16'h0, bus_a.CTRL}, {16'h0, W_ROBI});
    tick(); chk("add_t4", {16'h0, bus_a.CTRL}, 32'h0200);
    chk("add_step4", {29'h0, bus_a.STEP}, 32'd4);
    tick(); chk("add_wrap", {29'h0, bus_a.STEP}, 32'd0);
    #1; op = 4'h3;
    repeat (4) tick();
    chk("sub_t4", {16'h0, bus_a.CTRL}, 32'h0240);
    tick(); chk("sub_wrap", {29'h0, bus_a.STEP}, 32'd0);

    // JC taken / not taken
    #1; op = 4'h7; cf = 1'b1;
    repeat (2) tick();
    chk("jc_taken", {16'h0, bus_a.CTRL}, 32'h0883);
    tick(); chk("jc_taken_wrap", {29'h0, bus_a.STEP}, 32'd0);
    #1; cf = 1'b0;
    repeat (2) tick();
    chk("jc_not_taken", {16'h0, bus_a.CTRL}, 32'h0081);
    chk("jc_not_taken_step", {29'h0, bus_a.STEP}, 32'd2);
    tick(); chk("jc_nt_wrap", {29'h0, bus_a.STEP}, 32'd0);

    // HLT
    #1; op = 4'hF;
    repeat (2) tick();
    chk("hlt_t2", {16'h0, bus_a.CTRL}, 32'h8081);
    tick();
    chk("hlt_halted", {31'h0, bus_a.HALTED}, 32'h1);
    chk("hlt_step", {29'h0, bus_a.STEP}, 32'h0);
    repeat (12) tick();
    chk("hlt_hold_ctrl", {16'h0, bus_a.CTRL}, 32'h0081);
    chk("hlt_hold", {31'h0, bus_a.HALTED}, 32'h1);
    #1; clr = 1'b1; op = 4'h1;
    #1; chk("hlt_clr", {31'h0, bus_a.HALTED}, 32'h0);
    tick(); #1; clr = 1'b0;

    // LDA interrupted by asynchronous CLR at T3
    repeat (3) tick();
    chk("lda_t3", {16'h0, bus_a.CTRL}, 32'h1281);
    #2; clr = 1'b1;
    #1;
    chk("async_step", {29'h0, bus_a.STEP}, 32'h0);
    chk("async_ctrl", {16'h0, bus_a.CTRL}, 32'h0081);
    tick(); #1; clr = 1'b0; op = 4'h5;

    // LDI on the EARLY_END=0 instance pads T3/T4 with idle
    #1; chk("ldi_b_t0", {16'h0, bus_b.CTRL}, 32'h4085);
    tick(); chk("ldi_b_t1", {16'h0, bus_b.CTRL}, 32'h1489);
    tick(); chk("ldi_b_t2", {16'h0, bus_b.CTRL}, 32'h0A81);
    tick(); chk("ldi_b_t3", {16'h0, bus_b.CTRL}, 32'h0081);
    tick(); chk("ldi_b_t4", {16'h0, bus_b.CTRL}, 32'h0081);
    chk("ldi_b_step4", {29'h0, bus_b.STEP}, 32'd4);
    tick(); chk("ldi_b_wrap", {29'h0, bus_b.STEP}, 32'd0);

    // Randomized phase
    begin
      int halt_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
        @(posedge clk);
        #2;
        if (clr) begin
          clr = 1'b0;
        end else if (m_halt[0] && m_halt[1]) begin
          halt_cnt++;
          if (halt_cnt > 6) begin
            clr = 1'b1;
            halt_cnt = 0;
          end
        end else if ($urandom_range(0, 79) == 0) begin
          clr = 1'b1;
        end
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 29) == 0) op = 4'hF;
          else op = 4'($urandom_range(0, 14));
        end
        cf = 1'($urandom_range(0, 1));
        zf = 1'($urandom_range(0, 1));
      end
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
